// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding MEM-stage data access FSM (IDLE -> REQ -> DONE).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses without touching memory.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_mem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state;

    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, memop, is_byte, is_half;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        is_load_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;
    logic        unused_instr_bits;

    assign opcode   = instr_mem[6:2];
    assign funct3   = instr_mem[14:12];
    assign is_load  = (opcode == 5'b00000);
    assign is_store = (opcode == 5'b01000);
    assign memop    = is_load || is_store;
    assign stall    = ((state == IDLE) && memop) || (state == REQ);
    assign unused_instr_bits = ^{instr_mem[31:15], instr_mem[11:7], instr_mem[1:0]};

    // Stores use funct3 100/101 as plain word stores; only loads have unsigned variants.
    always_comb begin
        is_byte    = (funct3 == 3'b000) || (is_load && (funct3 == 3'b100));
        is_half    = (funct3 == 3'b001) || (is_load && (funct3 == 3'b101));
        be_next    = 4'b1111;
        wdata_next = wdata;
        if (is_store && is_byte) begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wdata[7:0]}};
        end else if (is_store && is_half) begin
            be_next    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{wdata[15:0]}};
        end
    end

    always_comb begin
        byte_sel = dmem_rdata[{offset_q, 3'b000} +: 8];
        half_sel = offset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_result = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_result = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_result = {24'd0, byte_sel};
            3'b101:  load_result = {16'd0, half_sel};
            default: load_result = dmem_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Request fields are latched on IDLE exit so upstream changes during REQ cannot disturb them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            rdata      <= 32'd0;
            done       <= 1'b0;
            funct3_q   <= 3'd0;
            offset_q   <= 2'd0;
            is_load_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    rdata <= 32'd0;
                    if (memop) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else
`endif
                        begin
                            state      <= REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_wdata <= wdata_next;
                            dmem_be    <= be_next;
                            funct3_q   <= funct3;
                            offset_q   <= addr[1:0];
                            is_load_q  <= is_load;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state    <= DONE;
                        dmem_req <= 1'b0;
                        done     <= 1'b1;
                        rdata    <= is_load_q ? load_result : 32'd0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    rdata <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Expected values are hand-computed from the byte-lane and sign-extension rules.
module tb_load_store_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LB  = 32'h0000_0003;
    localparam logic [31:0] LH  = 32'h0000_1003;
    localparam logic [31:0] LW  = 32'h0000_2003;
    localparam logic [31:0] LBU = 32'h0000_4003;
    localparam logic [31:0] LHU = 32'h0000_5003;
    localparam logic [31:0] SB  = 32'h0000_0023;
    localparam logic [31:0] SH  = 32'h0000_1023;
    localparam logic [31:0] SW  = 32'h0000_2023;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_mem, addr, wdata, dmem_addr, dmem_wdata, dmem_rdata, rdata;
    logic        dmem_req, dmem_we, dmem_ack, done, stall, misalign;
    logic [3:0]  dmem_be;

    int checks = 0;
    int failures = 0;

    int          stall_cnt, done_cnt, req_starts, done_cycle;
    logic [31:0] cap_addr, cap_wdata, rdata_cap;
    logic [3:0]  cap_be;
    logic        cap_we, mis_cap, stable;

    load_store_unit dut (
        .clk(clk), .reset(reset), .instr_mem(instr_mem), .addr(addr), .wdata(wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .rdata(rdata),
        .done(done), .stall(stall), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Presents one instruction, acks after ack_wait REQ cycles, scrambles upstream inputs during REQ.
    task automatic run_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] mem_word, input int ack_wait);
        int   req_cycles = 0;
        logic prev_req = 1'b0;
        logic seen_done = 1'b0;
        stall_cnt = 0; done_cnt = 0; req_starts = 0; done_cycle = 0;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        rdata_cap = 32'hXXXX_XXXX; mis_cap = 1'bx; stable = 1'b1;
        instr_mem = instr; addr = a; wdata = wd; dmem_rdata = mem_word; dmem_ack = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            #1;
            if (seen_done && !done) break;
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cycles++;
                if (!prev_req) begin
                    req_starts++;
                    cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
                end else if (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata ||
                             dmem_be !== cap_be || dmem_we !== cap_we) begin
                    stable = 1'b0;
                end
                instr_mem = SB; addr = 32'hFFFF_FFFF; wdata = 32'd0;
                dmem_ack = (req_cycles > ack_wait);
            end else begin
                dmem_ack = 1'b0;
            end
            prev_req = dmem_req;
            if (done) begin
                done_cnt++; seen_done = 1'b1; done_cycle = cyc;
                rdata_cap = rdata; mis_cap = misalign; instr_mem = NOP;
            end
            @(posedge clk);
        end
        dmem_ack = 1'b0;
        instr_mem = NOP;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_mem = NOP; addr = '0; wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b expected 0", dmem_req); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if ({dmem_addr, dmem_wdata, dmem_be, dmem_we} !== 69'd0) begin failures++; $display("[TB] FAIL reset_bus: got addr %h wdata %h be %b we %b expected all 0", dmem_addr, dmem_wdata, dmem_be, dmem_we); end
        reset = 1'b0;
    endtask

    task automatic test_store_word();
        run_op(SW, 32'h100, 32'hDEAD_BEEF, 32'd0, 1);
        checks++; if (cap_addr !== 32'h100) begin failures++; $display("[TB] FAIL sw_addr: got %h expected 00000100", cap_addr); end
        checks++; if (cap_be !== 4'b1111) begin failures++; $display("[TB] FAIL sw_be: got %b expected 1111", cap_be); end
        checks++; if (cap_we !== 1'b1) begin failures++; $display("[TB] FAIL sw_we: got %b expected 1", cap_we); end
        checks++; if (cap_wdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", cap_wdata); end
        checks++; if (stall_cnt !== 3) begin failures++; $display("[TB] FAIL sw_stall_cycles: got %0d expected 3", stall_cnt); end
        checks++; if (done_cnt !== 1) begin failures++; $display("[TB] FAIL sw_done_cycles: got %0d expected 1", done_cnt); end
        checks++; if (rdata_cap !== 32'd0) begin failures++; $display("[TB] FAIL sw_rdata: got %h expected 0", rdata_cap); end
        checks++; if (stable !== 1'b1) begin failures++; $display("[TB] FAIL sw_req_stable: got %b expected 1", stable); end
        checks++; if (mis_cap !== 1'b0) begin failures++; $display("[TB] FAIL sw_misalign: got %b expected 0", mis_cap); end
    endtask

    task automatic test_load_byte();
        run_op(LB, 32'h203, 32'd0, 32'h80FF_1234, 0);
        checks++; if (rdata_cap !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL lb_rdata: got %h expected ffffff80", rdata_cap); end
        checks++; if ({cap_addr, cap_be, cap_we} !== {32'h200, 4'b1111, 1'b0}) begin failures++; $display("[TB] FAIL lb_req: got addr %h be %b we %b expected 00000200 1111 0", cap_addr, cap_be, cap_we); end
        checks++; if (stall_cnt !== 2 || done_cycle !== 3) begin failures++; $display("[TB] FAIL lb_timing: got stall %0d done_cycle %0d expected 2 3", stall_cnt, done_cycle); end
        run_op(LBU, 32'h203, 32'd0, 32'h80FF_1234, 0);
        checks++; if (rdata_cap !== 32'h0000_0080) begin failures++; $display("[TB] FAIL lbu_rdata: got %h expected 00000080", rdata_cap); end
        run_op(LB, 32'h201, 32'd0, 32'h80FF_1234, 0);
        checks++; if (rdata_cap !== 32'h0000_0012) begin failures++; $display("[TB] FAIL lb_positive: got %h expected 00000012", rdata_cap); end
    endtask

    task automatic test_load_half_word();
        run_op(LH, 32'h202, 32'd0, 32'h80FF_1234, 2);
        checks++; if (rdata_cap !== 32'hFFFF_80FF) begin failures++; $display("[TB] FAIL lh_rdata: got %h expected ffff80ff", rdata_cap); end
        run_op(LHU, 32'h200, 32'd0, 32'h80FF_9234, 0);
        checks++; if (rdata_cap !== 32'h0000_9234) begin failures++; $display("[TB] FAIL lhu_rdata: got %h expected 00009234", rdata_cap); end
        run_op(LW, 32'h204, 32'd0, 32'h1234_5678, 0);
        checks++; if (rdata_cap !== 32'h1234_5678 || cap_addr !== 32'h204) begin failures++; $display("[TB] FAIL lw_rdata: got %h at %h expected 12345678 at 00000204", rdata_cap, cap_addr); end
    endtask

    task automatic test_store_sub_word();
        run_op(SH, 32'h12, 32'h0000_ABCD, 32'd0, 0);
        checks++; if ({cap_addr, cap_be, cap_wdata} !== {32'h10, 4'b1100, 32'hABCD_ABCD}) begin failures++; $display("[TB] FAIL sh_upper: got addr %h be %b wdata %h expected 00000010 1100 abcdabcd", cap_addr, cap_be, cap_wdata); end
        run_op(SH, 32'h20, 32'h1111_5A5A, 32'd0, 0);
        checks++; if ({cap_be, cap_wdata} !== {4'b0011, 32'h5A5A_5A5A}) begin failures++; $display("[TB] FAIL sh_lower: got be %b wdata %h expected 0011 5a5a5a5a", cap_be, cap_wdata); end
        run_op(SB, 32'h41, 32'h1234_5677, 32'd0, 0);
        checks++; if ({cap_addr, cap_be, cap_wdata} !== {32'h40, 4'b0010, 32'h7777_7777}) begin failures++; $display("[TB] FAIL sb_lane1: got addr %h be %b wdata %h expected 00000040 0010 77777777", cap_addr, cap_be, cap_wdata); end
        run_op(SB, 32'h43, 32'h0000_00C3, 32'd0, 0);
        checks++; if (cap_be !== 4'b1000) begin failures++; $display("[TB] FAIL sb_lane3: got be %b expected 1000", cap_be); end
    endtask

    task automatic test_reset_during_req();
        instr_mem = LW; addr = 32'h300; dmem_ack = 1'b0;
        @(posedge clk); #1;
        checks++; if (dmem_req !== 1'b1) begin failures++; $display("[TB] FAIL rst_req_entry: got %b expected 1", dmem_req); end
        instr_mem = NOP; reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin failures++; $display("[TB] FAIL rst_req_drop: got req %b stall %b expected 0 0", dmem_req, stall); end
        reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if ({done, dmem_req, rdata} !== 34'd0) begin failures++; $display("[TB] FAIL rst_late_ack: got done %b req %b rdata %h expected 0 0 0", done, dmem_req, rdata); end
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_misalign();
        run_op(LW, 32'h101, 32'd0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (req_starts !== 0) begin failures++; $display("[TB] FAIL mis_no_req: got %0d requests expected 0", req_starts); end
        checks++; if ({mis_cap, done_cnt, done_cycle} !== {1'b1, 32'd1, 32'd2}) begin failures++; $display("[TB] FAIL mis_trap: got misalign %b done %0d at cycle %0d expected 1 1 2", mis_cap, done_cnt, done_cycle); end
        checks++; if (rdata_cap !== 32'd0) begin failures++; $display("[TB] FAIL mis_rdata: got %h expected 0", rdata_cap); end
`else
        checks++; if (req_starts !== 1 || cap_addr !== 32'h100) begin failures++; $display("[TB] FAIL mis_forced_align: got %0d requests at %h expected 1 at 00000100", req_starts, cap_addr); end
        checks++; if (rdata_cap !== 32'hCAFE_F00D || mis_cap !== 1'b0) begin failures++; $display("[TB] FAIL mis_load: got rdata %h misalign %b expected cafef00d 0", rdata_cap, mis_cap); end
`endif
    endtask

    task automatic test_back_to_back();
        int          starts = 0;
        int          dones = 0;
        int          k = 0;
        logic        prev_req = 1'b0;
        logic [31:0] req_addr [2];
        logic        req_we [2];
        logic [31:0] rd0 = 32'd0;
        req_addr[0] = '0; req_addr[1] = '0; req_we[0] = 1'b0; req_we[1] = 1'b0;
        instr_mem = LW; addr = 32'h400; wdata = 32'd0; dmem_rdata = 32'h1122_3344;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (dmem_req && !prev_req) begin
                if (starts < 2) begin req_addr[starts] = dmem_addr; req_we[starts] = dmem_we; end
                starts++;
            end
            prev_req = dmem_req;
            dmem_ack = dmem_req;
            if (done) begin
                dones++;
                if (k == 0) begin rd0 = rdata; instr_mem = SW; addr = 32'h404; wdata = 32'h5566_7788; k = 1; end
                else begin instr_mem = NOP; k = 2; end
            end
            @(posedge clk);
        end
        dmem_ack = 1'b0; instr_mem = NOP;
        #1;
        checks++; if (starts !== 2 || dones !== 2) begin failures++; $display("[TB] FAIL b2b_counts: got %0d requests %0d dones expected 2 2", starts, dones); end
        checks++; if ({req_addr[0], req_we[0], req_addr[1], req_we[1]} !== {32'h400, 1'b0, 32'h404, 1'b1}) begin failures++; $display("[TB] FAIL b2b_reqs: got %h/%b then %h/%b expected 00000400/0 then 00000404/1", req_addr[0], req_we[0], req_addr[1], req_we[1]); end
        checks++; if (rd0 !== 32'h1122_3344) begin failures++; $display("[TB] FAIL b2b_load_data: got %h expected 11223344", rd0); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half_word();
        test_store_sub_word();
        test_reset_during_req();
        test_misalign();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: instr_mem  input  32  instruction in MEM stage; opcode instr_mem[6:2], funct3 instr_mem[14:12].
REQ-004 SHALL: addr  input  32  effective byte address (ALU result).
REQ-005 SHALL: wdata  input  32  store data (rs2 value).
REQ-006 SHALL: dmem_req  output  1  data-memory request; held high until dmem_ack.
REQ-007 SHALL: dmem_we  output  1  1 = store, 0 = load; valid while dmem_req.
REQ-008 SHALL: dmem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-009 SHALL: dmem_wdata  output  32  lane-aligned store data.
REQ-010 SHALL: dmem_be  output  4  byte enables; loads drive 4'b1111.
REQ-011 SHALL: dmem_ack  input  1  memory completion; dmem_rdata is valid in the same cycle.
REQ-012 SHALL: dmem_rdata  input  32  raw read word.
REQ-013 SHALL: rdata  output  32  extended load result; valid while done=1.
REQ-014 SHALL: done  output  1  one-cycle completion pulse.
REQ-015 SHALL: stall  output  1  holds PC/IF/ID/EX/MEM registers while 1.
REQ-016 SHALL: misalign  output  1  misaligned-access flag; tied 0 without REQ-031 macro.

Function
REQ-017 SHALL: decode memop as load if opcode==5'b00000, store if opcode==5'b01000, else none.
REQ-018 SHALL: implement FSM states IDLE, REQ, DONE.
REQ-019 SHALL: IDLE: memop present -> REQ; no memop -> stay IDLE.
REQ-020 SHALL: REQ: dmem_req=1 and dmem_we/addr/wdata/be latched at IDLE exit; stable until ack; dmem_ack=1 -> DONE, capturing dmem_rdata.
REQ-021 SHALL: DONE: done=1 for exactly one cycle -> IDLE; the next MEM-stage instruction is sampled in the following IDLE.
REQ-022 SHALL: stall = (IDLE and memop) or REQ; stall=0 in DONE so the pipeline advances once per memop.
REQ-023 SHALL: dmem_req=0 outside REQ; minimum memop occupancy 3 cycles (ack on the first REQ cycle).
REQ-024 SHALL: byte enables: SB (funct3 000) 4'b0001<<addr[1:0]; SH (001) 4'b0011 if addr[1]=0, else 4'b1100; SW and other funct3 4'b1111.
REQ-025 SHALL: dmem_wdata replicates byte wdata[7:0] x4 for SB, halfword wdata[15:0] x2 for SH, wdata for SW.
REQ-026 SHALL: load extraction: LB/LBU select byte addr[1:0], LH/LHU select half addr[1], LW full word; LB/LH sign-extend; LBU(100)/LHU(101) zero-extend; funct3 011/110/111 treated as LW.
REQ-027 SHALL: rdata=0 for stores and in all non-DONE states.
REQ-028 SHALL: instr_mem, addr and wdata changes during REQ do not alter the latched request.

Reset
REQ-029 SHALL: reset forces IDLE; dmem_req, dmem_we, done, stall-register state, misalign = 0; rdata, dmem_addr, dmem_wdata = 0; dmem_be = 0.
REQ-030 SHALL: reset asserted during REQ drops dmem_req next edge; a late dmem_ack while in IDLE is ignored.

Configuration
REQ-031 SHALL: macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW/word-class with addr[1:0]!=0, goes IDLE->DONE with no dmem_req; misalign=1 and done=1 in that DONE cycle; rdata=0.
REQ-032 SHALL: macro undefined: no misalign detection; misalign tied 0; low address bits beyond REQ-024/026 are ignored (forced alignment).

Verification
REQ-033 SHALL: SW addr=0x100, wdata=0xDEADBEEF, ack after 2 cycles -> dmem_addr=0x100, be=1111, we=1; stall high 3 cycles, then done=1 for 1 cycle.
REQ-034 SHALL: LB addr=0x203, dmem_rdata=0x80FF1234, ack immediate -> rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SHALL: SH addr=0x12, wdata=0x0000ABCD -> be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x10.
REQ-036 SHALL: reset pulsed during REQ with ack withheld -> dmem_req=0, stall=0 next cycle; subsequent ack produces no done.
REQ-037 SHALL: LW addr=0x101 -> with LSU_MISALIGN_TRAP_EN: no dmem_req, misalign=1, done=1 on second cycle; without: dmem_addr=0x100, normal load.
REQ-038 SHALL: back-to-back LW then SW -> two distinct requests, done pulsed twice, no duplicate request for either instruction.
